// File: rtl/ov7670_cfg_pkg.sv
// Shared constants and FSM state encoding for the OV7670 register
// configuration sequencer.
package ov7670_cfg_pkg;

  localparam logic [15:0] CMD_END   = 16'hFFFF;
  localparam logic [15:0] CMD_DELAY = 16'hFFF0;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    DECODE,
    SEND,
    WAIT_BUSY,
    WAIT_DONE,
    DELAY,
    FINISH
  } cfg_state_t;

endpackage

// File: rtl/cfg_delay_timer.sv
// Down-counter for delay entries: i_load arms it for CYCLES cycles,
// o_expire is high on the last of them.
module cfg_delay_timer #(
  parameter int unsigned CYCLES = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic i_load,
  output logic o_expire
);

  localparam int unsigned CYC = (CYCLES < 1) ? 1 : CYCLES;
  localparam int W = $clog2(CYC + 1);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= W'(CYC - 1);
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_expire = (r_cnt == '0);

endmodule

// File: rtl/ov7670_config_seq.sv
// Walks a register ROM and issues SCCB writes / timed delays.
// Define OV7670_CFG_NACK_RETRY_EN to add sccb_nack and per-entry retries.
module ov7670_config_seq
  import ov7670_cfg_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ = 25000000,
  parameter int unsigned DELAY_MS    = 10,
  parameter int unsigned MAX_RETRY   = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic [7:0]  rom_addr,
  input  logic [15:0] rom_dout,
  output logic        sccb_start,
  output logic [7:0]  sccb_reg,
  output logic [7:0]  sccb_val,
  input  logic        sccb_ready,
`ifdef OV7670_CFG_NACK_RETRY_EN
  input  logic        sccb_nack,
`endif
  output logic        busy,
  output logic        done,
  output logic        error
);

  localparam int unsigned DLY_CYC = (DELAY_MS * CLK_FREQ_HZ) / 1000;

  cfg_state_t r_state, w_next;
  logic [7:0] r_addr;
  logic [7:0] r_reg;
  logic [7:0] r_val;
  logic       r_done;
  logic       w_start, w_load, w_latch, w_adv;
  logic       w_clr, w_done_set, w_expire;

`ifdef OV7670_CFG_NACK_RETRY_EN
  localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
  logic [RW-1:0] r_retry;
  logic          r_error;
  logic          w_retry_inc, w_err_set;
`endif

  cfg_delay_timer #(.CYCLES(DLY_CYC)) u_dly (
    .clk      (clk),
    .rst      (rst),
    .i_load   (w_load),
    .o_expire (w_expire)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    w_start    = 1'b0;
    w_load     = 1'b0;
    w_latch    = 1'b0;
    w_adv      = 1'b0;
    w_clr      = 1'b0;
    w_done_set = 1'b0;
`ifdef OV7670_CFG_NACK_RETRY_EN
    w_retry_inc = 1'b0;
    w_err_set   = 1'b0;
`endif
    unique case (r_state)
      IDLE: if (start) begin
        w_clr  = 1'b1;
        w_next = FETCH;
      end
      FETCH: w_next = DECODE;
      DECODE: begin
        if (rom_dout == CMD_END) begin
          w_next = FINISH;
        end else if (rom_dout == CMD_DELAY) begin
          w_load = 1'b1;
          w_next = DELAY;
        end else begin
          w_latch = 1'b1;
          w_next  = SEND;
        end
      end
      SEND: if (sccb_ready) begin
        w_start = 1'b1;
        w_next  = WAIT_BUSY;
      end
      WAIT_BUSY: if (!sccb_ready) w_next = WAIT_DONE;
      WAIT_DONE: if (sccb_ready) begin
`ifdef OV7670_CFG_NACK_RETRY_EN
        if (sccb_nack && r_retry != RW'(MAX_RETRY)) begin
          w_retry_inc = 1'b1;
          w_next      = SEND;
        end else begin
          w_err_set = sccb_nack;
          w_adv     = 1'b1;
        end
`else
        w_adv = 1'b1;
`endif
      end
      DELAY: if (w_expire) w_adv = 1'b1;
      FINISH: begin
        w_done_set = 1'b1;
        w_next     = IDLE;
      end
      default: w_next = IDLE;
    endcase
    // Address 255 is the last slot; running past it ends the sequence.
    if (w_adv) w_next = (r_addr == 8'hFF) ? FINISH : FETCH;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr <= '0;
      r_reg  <= '0;
      r_val  <= '0;
      r_done <= 1'b0;
    end else begin
      if (w_clr) begin
        r_addr <= '0;
        r_done <= 1'b0;
      end
      if (w_latch) {r_reg, r_val} <= rom_dout;
      if (w_adv && r_addr != 8'hFF) r_addr <= r_addr + 1'b1;
      if (w_done_set) r_done <= 1'b1;
    end
  end

`ifdef OV7670_CFG_NACK_RETRY_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_retry <= '0;
      r_error <= 1'b0;
    end else begin
      if (w_clr) r_error <= 1'b0;
      if (w_err_set) r_error <= 1'b1;
      if (w_clr || w_adv) r_retry <= '0;
      else if (w_retry_inc) r_retry <= r_retry + 1'b1;
    end
  end

  assign error = r_error;
`else
  assign error = 1'b0;
`endif

  assign rom_addr   = r_addr;
  assign sccb_reg   = r_reg;
  assign sccb_val   = r_val;
  assign sccb_start = w_start;
  assign busy       = (r_state != IDLE);
  assign done       = r_done;

endmodule

// File: doc/ov7670_config_seq.md
OV7670_CONFIG_SEQ -- requirements
Module: ov7670_config_seq

Interface
REQ-001 SHALL have parameter CLK_FREQ_HZ, default 25000000, system clock frequency.
REQ-002 SHALL have parameter DELAY_MS, default 10, duration of a delay entry.
REQ-003 SHALL have parameter MAX_RETRY, default 3, NACK retries per entry (retry build only).
REQ-004 SHALL have port clk, input, 1, single clock for all logic.
REQ-005 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-006 SHALL have port start, input, 1, one-cycle request to run the configuration sequence.
REQ-007 SHALL have port rom_addr, output, 8, ROM entry address.
REQ-008 SHALL have port rom_dout, input, 16, ROM word {reg[15:8], value[7:0]}, valid 1 cycle after rom_addr.
REQ-009 SHALL have port sccb_start, output, 1, one-cycle write request to the SCCB master.
REQ-010 SHALL have port sccb_reg, output, 8, register address for the write.
REQ-011 SHALL have port sccb_val, output, 8, data byte for the write.
REQ-012 SHALL have port sccb_ready, input, 1, SCCB master idle/accepting.
REQ-013 SHALL have port sccb_nack, input, 1, NACK flag, valid when sccb_ready rises (retry build only).
REQ-014 SHALL have port busy, output, 1, sequence in progress.
REQ-015 SHALL have port done, output, 1, sticky completion flag.
REQ-016 SHALL have port error, output, 1, sticky flag set when any entry exhausts its retries.

Function
REQ-017 SHALL use FSM states IDLE, FETCH, DECODE, SEND, WAIT_BUSY, WAIT_DONE, DELAY, FINISH.
REQ-018 SHALL move IDLE->FETCH on start=1, with rom_addr=0 and done/error cleared.
REQ-019 SHALL hold FETCH for exactly 1 cycle to cover ROM latency, then go to DECODE.
REQ-020 SHALL, in DECODE: on 16'hFFFF go to FINISH; on 16'hFFF0 go to DELAY; otherwise latch sccb_reg/sccb_val and go to SEND.
REQ-021 SHALL, in SEND, pulse sccb_start for one cycle only in a cycle where sccb_ready=1, then go to WAIT_BUSY.
REQ-022 SHALL leave WAIT_BUSY when sccb_ready=0.
REQ-023 SHALL leave WAIT_DONE when sccb_ready=1, then increment rom_addr and go to FETCH.
REQ-024 SHALL count DELAY_MS*CLK_FREQ_HZ/1000 cycles in DELAY, then increment rom_addr and go to FETCH.
REQ-025 SHALL treat rom_addr wrap from 255 as the end of the sequence: go to FINISH, no wrap to 0.
REQ-026 SHALL set done=1 in FINISH, return to IDLE, and hold done until the next start or rst.
REQ-027 SHALL hold busy=1 in every state except IDLE.
REQ-028 SHALL ignore start while busy=1.
REQ-029 SHALL keep sccb_reg/sccb_val stable from SEND until WAIT_DONE exits.

Reset
REQ-030 SHALL, on rst=1 at any time including mid-transfer or mid-delay, force IDLE.
REQ-031 SHALL reset rom_addr, sccb_reg, sccb_val, the delay counter and the retry counter to 0.
REQ-032 SHALL reset sccb_start, busy, done and error to 0.

Configuration
REQ-033 SHALL, when OV7670_CFG_NACK_RETRY_EN is defined, include port sccb_nack: at WAIT_DONE exit with sccb_nack=1, resend the same entry (back to SEND) up to MAX_RETRY times.
REQ-034 SHALL, in the retry build, set error=1 once an entry exhausts its retries, then advance to the next entry.
REQ-035 SHALL, without OV7670_CFG_NACK_RETRY_EN, omit port sccb_nack, perform no retries, and tie error to 0.

Structure
REQ-036 SHALL take the 16'hFFFF and 16'hFFF0 constants and the FSM state enum from shared package ov7670_cfg_pkg.
REQ-037 SHALL put the delay counter in sub-module cfg_delay_timer, with load/expire handshake and width derived from the cycle count.

Verification
REQ-038 SHALL check: ROM {1280, FFFF}, start pulse -> one sccb_start with reg=0x12, val=0x80, then done=1, busy=0.
REQ-039 SHALL check: entry 1 = FFF0 with CLK_FREQ_HZ=1000000, DELAY_MS=1 -> exactly 1000 cycles with no sccb_start before fetching entry 2.
REQ-040 SHALL check: sccb_ready held 0 for 50 cycles during SEND -> no sccb_start until sccb_ready=1, then a single pulse.
REQ-041 SHALL check: rst asserted in WAIT_DONE -> all outputs 0 the same cycle; next start restarts at rom_addr=0.
REQ-042 SHALL check in the retry build: sccb_nack=1 on every transfer, MAX_RETRY=3 -> 4 sccb_start pulses for the entry, error=1, then the next entry proceeds.
REQ-043 SHALL check: 256 non-terminal entries -> done=1 after entry 255 with no address wrap.
